alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the combinational 32-bit ALU. Adds XOR, unsigned multiply, divide and remainder, a registered flag set, and valid/ready handshakes on both sides. Sits between the decode stage and the register-file writeback: one operation in flight at a time, with back-pressure from writeback.

---
 rtl/alu_mc.sv | 181 ++++++++++++++++++
 tb/tb_alu_mc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL/DIVU/REMU,
// one operation in flight, valid/ready handshake on both sides, registered flags.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             is_zero,
    output logic             is_neg,
    output logic             carry,
    output logic             ovf,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0]       CNT_END = WIDTH[SHW:0];
    localparam logic [WIDTH-1:0]   W_VAL   = WIDTH[WIDTH-1:0];

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SHL  = 4'b0010;
    localparam logic [3:0] OP_SHR  = 4'b0011;
    localparam logic [3:0] OP_PASS = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [1:0] {IDLE, ONE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic             accept, finish, step;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, acc, sh;
    logic [SHW:0]     cnt;

    // iterative datapath signals
    logic [WIDTH:0]   trial;
    logic             div_borrow;
    logic [WIDTH-1:0] div_rem;

    // result and flags of the operation being completed
    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] res;
    logic             res_carry, res_ovf, res_err;

    function automatic logic is_iter(input logic [3:0] o);
        return (o == OP_MUL) || (o == OP_DIVU) || (o == OP_REMU);
    endfunction

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign step     = (state == BUSY) && (cnt != CNT_END);
    assign finish   = (state == ONE) || ((state == BUSY) && (cnt == CNT_END));

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state logic; an accept in DONE chains straight into the next op
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = is_iter(op) ? BUSY : ONE;
            ONE:  state_nxt = DONE;
            BUSY: if (cnt == CNT_END) state_nxt = DONE;
            DONE: begin
                if (accept)         state_nxt = is_iter(op) ? BUSY : ONE;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // step counter for the iterative ops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    cnt <= '0;
        else if (accept) cnt <= '0;
        else if (step)   cnt <= cnt + 1'b1;
    end

    // one restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial      = {acc, sh[WIDTH-1]};
        div_borrow = trial < {1'b0, b_q};
        div_rem    = trial[WIDTH-1:0] - b_q;
    end

    // operand latch and iteration registers; MUL shifts a_q left and sh right,
    // DIVU/REMU shift the dividend out of sh and the quotient bits into it
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op;
            a_q  <= in0;
            b_q  <= in1;
            acc  <= '0;
            sh   <= (op == OP_MUL) ? in1 : in0;
        end else if (step) begin
            if (op_q == OP_MUL) begin
                acc <= acc + (sh[0] ? a_q : '0);
                a_q <= a_q << 1;
                sh  <= sh >> 1;
            end else begin
                acc <= div_borrow ? trial[WIDTH-1:0] : div_rem;
                sh  <= {sh[WIDTH-2:0], ~div_borrow};
            end
        end
    end

    // final result and flags from the latched operands / iteration registers
    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        res_err   = 1'b0;
        sum       = {1'b0, a_q} + {1'b0, b_q};
        dif       = {1'b0, a_q} - {1'b0, b_q};
        case (op_q)
            OP_ADD: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res       = dif[WIDTH-1:0];
                res_carry = ~dif[WIDTH];
                res_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SHL:  res = (b_q >= W_VAL) ? '0 : (a_q << b_q[SHW-1:0]);
            OP_SHR:  res = (b_q >= W_VAL) ? '0 : (a_q >> b_q[SHW-1:0]);
            OP_PASS: res = a_q;
            OP_AND:  res = a_q & b_q;
            OP_OR:   res = a_q | b_q;
            OP_XOR:  res = a_q ^ b_q;
            OP_MUL:  res = acc;
            OP_DIVU: begin
                res     = sh;
                res_err = (b_q == '0);
            end
            OP_REMU: begin
                res     = acc;
                res_err = (b_q == '0);
            end
            default: res_err = 1'b1;
        endcase
    end

    // output register: captured once on completion, held until consumed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            is_zero   <= 1'b0;
            is_neg    <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else if (finish) begin
            out       <= res;
            out_valid <= 1'b1;
            is_zero   <= (res == '0);
            is_neg    <= res[WIDTH-1];
            carry     <= res_carry;
            ovf       <= res_ovf;
            err       <= res_err;
        end else if ((state == DONE) && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: WIDTH=32 and WIDTH=8 instances, hand-computed vectors.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] in0 = '0, in1 = '0;
    logic        in_ready, out_valid, is_zero, is_neg, carry, ovf, err;
    logic [31:0] out;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
    logic [3:0]  op8 = '0;
    logic [7:0]  in0_8 = '0, in1_8 = '0;
    logic        in_ready8, out_valid8, is_zero8, is_neg8, carry8, ovf8, err8;
    logic [7:0]  out8;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [4:0]  fl_hold;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in0(in0), .in1(in1), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .is_zero(is_zero), .is_neg(is_neg), .carry(carry), .ovf(ovf), .err(err)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .in0(in0_8), .in1(in1_8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .is_zero(is_zero8), .is_neg(is_neg8), .carry(carry8), .ovf(ovf8), .err(err8)
    );

    function automatic logic [4:0] flags32();
        return {is_zero, is_neg, carry, ovf, err};
    endfunction

    function automatic logic [4:0] flags8();
        return {is_zero8, is_neg8, carry8, ovf8, err8};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // present an op for one edge (block must be ready), scramble inputs, wait for out_valid
    task automatic issue32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int l);
        op = o; in0 = a; in1 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'b0110; in0 = 32'hDEADBEEF; in1 = 32'h12345678;
        l = 0;
        do begin @(posedge clk); #1; l++; end while (!out_valid && l < 100);
    endtask

    task automatic issue8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, output int l);
        op8 = o; in0_8 = a; in1_8 = b; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; in0_8 = 8'hA5; in1_8 = 8'h3C;
        l = 0;
        do begin @(posedge clk); #1; l++; end while (!out_valid8 && l < 100);
    endtask

    task automatic consume32();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic consume8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic run32(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_out, input logic [4:0] e_fl, input int e_lat);
        int l;
        issue32(o, a, b, l);
        chk({tag, " lat"}, l, e_lat);
        chk({tag, " out"}, out, e_out);
        chk({tag, " flags"}, {27'd0, flags32()}, {27'd0, e_fl});
        consume32();
    endtask

    task automatic run8(input string tag, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] e_out, input logic [4:0] e_fl, input int e_lat);
        int l;
        issue8(o, a, b, l);
        chk({tag, " lat"}, l, e_lat);
        chk({tag, " out"}, {24'd0, out8}, {24'd0, e_out});
        chk({tag, " flags"}, {27'd0, flags8()}, {27'd0, e_fl});
        consume8();
    endtask

    // flags order: {is_zero, is_neg, carry, ovf, err}
    initial begin
        #12;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out", out, 32'd0);
        chk("rst flags", {27'd0, flags32()}, 32'd0);
        #10 reset_n = 1'b1;
        #1;
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);

        run32("add", 4'b0000, 32'd2536, 32'd113, 32'd2649, 5'b00000, 1);
        run32("add wrap", 4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0, 5'b10100, 1);
        run32("sub eq", 4'b0001, 32'd2536, 32'd2536, 32'd0, 5'b10100, 1);
        run32("sub ovf", 4'b0001, 32'h80000000, 32'd1, 32'h7FFFFFFF, 5'b00110, 1);
        run32("sub borrow", 4'b0001, 32'd1, 32'd2, 32'hFFFFFFFF, 5'b01000, 1);
        run32("shl", 4'b0010, 32'd2536, 32'd2, 32'd10144, 5'b00000, 1);
        run32("shr", 4'b0011, 32'd2536, 32'd4, 32'd158, 5'b00000, 1);
        run32("shl 40", 4'b0010, 32'd2536, 32'd40, 32'd0, 5'b10000, 1);
        run32("pass", 4'b0100, 32'h80000001, 32'd7, 32'h80000001, 5'b01000, 1);
        run32("and", 4'b0101, 32'd2536, 32'd113, 32'd96, 5'b00000, 1);
        run32("or", 4'b0110, 32'd2536, 32'd3113, 32'd3561, 5'b00000, 1);
        run32("xor", 4'b0111, 32'd2536, 32'd113, 32'd2457, 5'b00000, 1);
        run32("illegal", 4'b1111, 32'd2536, 32'd113, 32'd0, 5'b10001, 1);
        run32("mul", 4'b1000, 32'd2536, 32'd113, 32'd286568, 5'b00000, 33);
        run32("divu", 4'b1001, 32'd2536, 32'd113, 32'd22, 5'b00000, 33);
        run32("remu", 4'b1010, 32'd2536, 32'd113, 32'd50, 5'b00000, 33);
        run32("divu0", 4'b1001, 32'd5, 32'd0, 32'hFFFFFFFF, 5'b01001, 33);
        run32("remu0", 4'b1010, 32'd5, 32'd0, 32'd5, 5'b00001, 33);

        // back-pressure: hold out_ready low in DONE for 5 cycles
        issue32(4'b0000, 32'd7, 32'd8, lat);
        chk("hold lat", lat, 1);
        fl_hold = flags32();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold valid", {31'd0, out_valid}, 32'd1);
            chk("hold out", out, 32'd15);
            chk("hold flags", {27'd0, flags32()}, {27'd0, fl_hold});
            chk("hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        // consume and accept a new op on the same edge
        op = 4'b0001; in0 = 32'd10; in1 = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("chain in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; in0 = 32'hDEADBEEF;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 100);
        chk("chain lat", lat, 1);
        chk("chain out", out, 32'd7);
        chk("chain flags", {27'd0, flags32()}, {27'd0, 5'b00100});
        consume32();

        // reset 10 cycles into a MUL
        op = 4'b1000; in0 = 32'd2536; in1 = 32'd113; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy in_ready", {31'd0, in_ready}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst out", out, 32'd0);
        chk("arst out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst flags", {27'd0, flags32()}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        chk("aborted no result", lat, 0);
        run32("add after rst", 4'b0000, 32'd1, 32'd1, 32'd2, 5'b00000, 1);

        // WIDTH = 8 instance
        run8("w8 mul", 4'b1000, 8'd15, 8'd17, 8'd255, 5'b01000, 9);
        run8("w8 shl 8", 4'b0010, 8'd1, 8'd8, 8'd0, 5'b10000, 1);
        run8("w8 shl 7", 4'b0010, 8'd1, 8'd7, 8'h80, 5'b01000, 1);
        run8("w8 divu", 4'b1001, 8'd200, 8'd7, 8'd28, 5'b00000, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
